// File: rtl/regfile_issue_arb.sv
// Issue arbiter for a 2R1W register file: one holding slot per channel, conflict-free issue with age-based fairness.
// Optional build macro REGFILE_ISSUE_ARB_STATS_EN adds the stall_cnt output.
module regfile_issue_arb #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [4:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd1_valid,
  output logic                  rd1_ready,
  input  logic [4:0]            rd1_addr,
  input  logic                  rd2_valid,
  output logic                  rd2_ready,
  input  logic [4:0]            rd2_addr,
  output logic                  wen1,
  output logic                  ren1,
  output logic                  ren2,
  output logic [4:0]            wad1,
  output logic [4:0]            rad1,
  output logic [4:0]            rad2,
  output logic [DATA_WIDTH-1:0] din
`ifdef REGFILE_ISSUE_ARB_STATS_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  logic                  r_wr_vld, r_rd1_vld, r_rd2_vld;
  logic [4:0]            r_wr_addr, r_rd1_addr, r_rd2_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [1:0]            r_wr_wait, r_rd1_wait, r_rd2_wait;

  logic                  r_wen1, r_ren1, r_ren2;
  logic [4:0]            r_wad1, r_rad1, r_rad2;
  logic [DATA_WIDTH-1:0] r_din;

  logic w_c12, w_cw1, w_cw2;
  logic w_1_beats_2, w_1_beats_w, w_2_beats_w;
  logic w_wr_iss, w_rd1_iss, w_rd2_iss;
  logic w_any_stall;

  assign w_c12 = r_rd1_vld && r_rd2_vld && (r_rd1_addr == r_rd2_addr);
  assign w_cw1 = r_wr_vld  && r_rd1_vld && (r_wr_addr  == r_rd1_addr);
  assign w_cw2 = r_wr_vld  && r_rd2_vld && (r_wr_addr  == r_rd2_addr);

  // Ties resolve rd1 > rd2 > wr, hence >= in favour of the higher-priority side.
  assign w_1_beats_2 = (r_rd1_wait >= r_rd2_wait);
  assign w_1_beats_w = (r_rd1_wait >= r_wr_wait);
  assign w_2_beats_w = (r_rd2_wait >= r_wr_wait);

  assign w_rd1_iss = r_rd1_vld && !(w_c12 && !w_1_beats_2) && !(w_cw1 && !w_1_beats_w);
  assign w_rd2_iss = r_rd2_vld && !(w_c12 &&  w_1_beats_2) && !(w_cw2 && !w_2_beats_w);
  assign w_wr_iss  = r_wr_vld  && !(w_cw1 &&  w_1_beats_w) && !(w_cw2 &&  w_2_beats_w);

  assign w_any_stall = (r_wr_vld && !w_wr_iss) || (r_rd1_vld && !w_rd1_iss) ||
                       (r_rd2_vld && !w_rd2_iss);

  assign wr_ready  = !r_wr_vld  || w_wr_iss;
  assign rd1_ready = !r_rd1_vld || w_rd1_iss;
  assign rd2_ready = !r_rd2_vld || w_rd2_iss;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_vld  <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_wait <= 2'd0;
    end else if (wr_valid && wr_ready) begin
      r_wr_vld  <= 1'b1;
      r_wr_addr <= wr_addr;
      r_wr_data <= wr_data;
      r_wr_wait <= 2'd0;
    end else if (w_wr_iss) begin
      r_wr_vld  <= 1'b0;
      r_wr_wait <= 2'd0;
    end else if (r_wr_vld && r_wr_wait != 2'd3) begin
      r_wr_wait <= r_wr_wait + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd1_vld  <= 1'b0;
      r_rd1_addr <= '0;
      r_rd1_wait <= 2'd0;
    end else if (rd1_valid && rd1_ready) begin
      r_rd1_vld  <= 1'b1;
      r_rd1_addr <= rd1_addr;
      r_rd1_wait <= 2'd0;
    end else if (w_rd1_iss) begin
      r_rd1_vld  <= 1'b0;
      r_rd1_wait <= 2'd0;
    end else if (r_rd1_vld && r_rd1_wait != 2'd3) begin
      r_rd1_wait <= r_rd1_wait + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd2_vld  <= 1'b0;
      r_rd2_addr <= '0;
      r_rd2_wait <= 2'd0;
    end else if (rd2_valid && rd2_ready) begin
      r_rd2_vld  <= 1'b1;
      r_rd2_addr <= rd2_addr;
      r_rd2_wait <= 2'd0;
    end else if (w_rd2_iss) begin
      r_rd2_vld  <= 1'b0;
      r_rd2_wait <= 2'd0;
    end else if (r_rd2_vld && r_rd2_wait != 2'd3) begin
      r_rd2_wait <= r_rd2_wait + 2'd1;
    end
  end

  // Strobes pulse for one cycle; addresses and data hold when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wen1 <= 1'b0;
      r_ren1 <= 1'b0;
      r_ren2 <= 1'b0;
      r_wad1 <= '0;
      r_rad1 <= '0;
      r_rad2 <= '0;
      r_din  <= '0;
    end else begin
      r_wen1 <= w_wr_iss;
      r_ren1 <= w_rd1_iss;
      r_ren2 <= w_rd2_iss;
      if (w_wr_iss) begin
        r_wad1 <= r_wr_addr;
        r_din  <= r_wr_data;
      end
      if (w_rd1_iss) r_rad1 <= r_rd1_addr;
      if (w_rd2_iss) r_rad2 <= r_rd2_addr;
    end
  end

  assign wen1 = r_wen1;
  assign ren1 = r_ren1;
  assign ren2 = r_ren2;
  assign wad1 = r_wad1;
  assign rad1 = r_rad1;
  assign rad2 = r_rad2;
  assign din  = r_din;

`ifdef REGFILE_ISSUE_ARB_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= 16'd0;
    end else if (w_any_stall && r_stall_cnt != 16'hFFFF) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  logic w_unused_stall;
  assign w_unused_stall = w_any_stall;
`endif

endmodule

// File: tb/tb_regfile_issue_arb.sv
// Bench for regfile_issue_arb: vector table, directed corner sequences, and a randomized run against a slot model.
module tb_regfile_issue_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid, rd1_valid, rd2_valid;
  logic        wr_ready, rd1_ready, rd2_ready;
  logic [4:0]  wr_addr, rd1_addr, rd2_addr;
  logic [15:0] wr_data;
  logic        wen1, ren1, ren2;
  logic [4:0]  wad1, rad1, rad2;
  logic [15:0] din;
`ifdef REGFILE_ISSUE_ARB_STATS_EN
  logic [15:0] stall_cnt;
`endif

  regfile_issue_arb #(.DATA_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd1_valid(rd1_valid), .rd1_ready(rd1_ready), .rd1_addr(rd1_addr),
    .rd2_valid(rd2_valid), .rd2_ready(rd2_ready), .rd2_addr(rd2_addr),
    .wen1(wen1), .ren1(ren1), .ren2(ren2),
    .wad1(wad1), .rad1(rad1), .rad2(rad2), .din(din)
`ifdef REGFILE_ISSUE_ARB_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_valid  = 1'b0;
    rd1_valid = 1'b0;
    rd2_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  // Strobe vectors are {wen1, ren1, ren2}; ready vectors are {wr, rd1, rd2}.
  typedef struct {
    bit        wv;
    bit [4:0]  wa;
    bit [15:0] wd;
    bit        r1v;
    bit [4:0]  r1a;
    bit        r2v;
    bit [4:0]  r2a;
    bit [2:0]  rdy;
    bit [2:0]  s0;
    bit [2:0]  s1;
    bit [2:0]  s2;
  } vec_t;

  function automatic vec_t mk(bit wv, bit [4:0] wa, bit [15:0] wd, bit r1v, bit [4:0] r1a,
                              bit r2v, bit [4:0] r2a, bit [2:0] rdy,
                              bit [2:0] s0, bit [2:0] s1, bit [2:0] s2);
    vec_t v;
    v.wv = wv; v.wa = wa; v.wd = wd; v.r1v = r1v; v.r1a = r1a; v.r2v = r2v; v.r2a = r2a;
    v.rdy = rdy; v.s0 = s0; v.s1 = s1; v.s2 = s2;
    return v;
  endfunction

  function automatic int pri(int k);
    return 2 - k;  // index 0=rd1, 1=rd2, 2=wr
  endfunction

  // Behavioural model state
  bit        mv[3];
  bit [4:0]  ma[3];
  int        mw[3];
  bit [15:0] mdat;
  bit [2:0]  e_stb;
  bit [4:0]  e_wad, e_rad1, e_rad2;
  bit [15:0] e_din;
  int        e_stall;

  vec_t tbl[8];

  initial begin
    idle_inputs();
    wr_addr = '0; wr_data = '0; rd1_addr = '0; rd2_addr = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("reset_strobes", 32'({wen1, ren1, ren2}), 32'd0);
    chk("reset_addrs", 32'({wad1, rad1, rad2}), 32'd0);
    chk("reset_din", 32'(din), 32'd0);
    chk("reset_ready", 32'({wr_ready, rd1_ready, rd2_ready}), 32'h7);
`ifdef REGFILE_ISSUE_ARB_STATS_EN
    chk("reset_stall", 32'(stall_cnt), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    tick();

    // ---------------- table-driven single transactions from idle
    tbl[0] = mk(1, 5'd3,  16'hBEEF, 0, 5'd0,  0, 5'd0,  3'b111, 3'b100, 3'b000, 3'b000);
    tbl[1] = mk(1, 5'd5,  16'hA5A5, 1, 5'd6,  1, 5'd7,  3'b111, 3'b111, 3'b000, 3'b000);
    tbl[2] = mk(0, 5'd0,  16'h0000, 1, 5'd9,  1, 5'd9,  3'b110, 3'b010, 3'b001, 3'b000);
    tbl[3] = mk(1, 5'd4,  16'h1111, 1, 5'd4,  0, 5'd0,  3'b011, 3'b010, 3'b100, 3'b000);
    tbl[4] = mk(1, 5'd8,  16'h2222, 0, 5'd0,  1, 5'd8,  3'b011, 3'b001, 3'b100, 3'b000);
    tbl[5] = mk(1, 5'd10, 16'h3333, 1, 5'd10, 1, 5'd10, 3'b010, 3'b010, 3'b001, 3'b100);
    tbl[6] = mk(1, 5'd1,  16'h4444, 1, 5'd1,  1, 5'd2,  3'b011, 3'b011, 3'b100, 3'b000);
    tbl[7] = mk(0, 5'd0,  16'h0000, 1, 5'd0,  0, 5'd0,  3'b111, 3'b010, 3'b000, 3'b000);

    for (int v = 0; v < 8; v++) begin
      bit [2:0] sc[3];
`ifdef REGFILE_ISSUE_ARB_STATS_EN
      int st0;
      st0 = int'(stall_cnt);
`endif
      sc[0] = tbl[v].s0; sc[1] = tbl[v].s1; sc[2] = tbl[v].s2;
      wr_valid = tbl[v].wv;   wr_addr = tbl[v].wa;   wr_data = tbl[v].wd;
      rd1_valid = tbl[v].r1v; rd1_addr = tbl[v].r1a;
      rd2_valid = tbl[v].r2v; rd2_addr = tbl[v].r2a;
      tick();
      idle_inputs();
      chk($sformatf("vec%0d_ready", v), 32'({wr_ready, rd1_ready, rd2_ready}), 32'(tbl[v].rdy));
      for (int c = 0; c < 3; c++) begin
        tick();
        chk($sformatf("vec%0d_stb%0d", v, c), 32'({wen1, ren1, ren2}), 32'(sc[c]));
        if (sc[c][2]) begin
          chk($sformatf("vec%0d_wad", v), 32'(wad1), 32'(tbl[v].wa));
          chk($sformatf("vec%0d_din", v), 32'(din), 32'(tbl[v].wd));
        end
        if (sc[c][1]) chk($sformatf("vec%0d_rad1", v), 32'(rad1), 32'(tbl[v].r1a));
        if (sc[c][0]) chk($sformatf("vec%0d_rad2", v), 32'(rad2), 32'(tbl[v].r2a));
      end
`ifdef REGFILE_ISSUE_ARB_STATS_EN
      chk($sformatf("vec%0d_stall", v), 32'(int'(stall_cnt) - st0),
          32'(int'(tbl[v].s1 != 3'b000) + int'(tbl[v].s2 != 3'b000)));
`endif
    end

    // ---------------- aged write beats a fresh read of the same address
    wr_valid = 1'b1; wr_addr = 5'd4; wr_data = 16'h1234;
    rd2_valid = 1'b1; rd2_addr = 5'd4;
    tick();
    idle_inputs();
    rd1_valid = 1'b1; rd1_addr = 5'd4;
    chk("age_wr_held", 32'({wr_ready, rd1_ready}), 32'b01);
    tick();
    idle_inputs();
    chk("age_rd2_first", 32'({wen1, ren1, ren2}), 32'b001);
    tick();
    chk("age_wr_second", 32'({wen1, ren1, ren2}), 32'b100);
    chk("age_wr_addr", 32'({wad1, din}), 32'({5'd4, 16'h1234}));
    tick();
    chk("age_rd1_third", 32'({wen1, ren1, ren2}), 32'b010);

    // ---------------- reset while slots are holding requests
    wr_valid = 1'b1; wr_addr = 5'd10; wr_data = 16'h5555;
    rd1_valid = 1'b1; rd1_addr = 5'd10;
    rd2_valid = 1'b1; rd2_addr = 5'd10;
    tick();
    idle_inputs();
    tick();
    chk("rst_mid_pre", 32'({ren1, rad1}), 32'({1'b1, 5'd10}));
    reset = 1'b1;
    #1;
    chk("rst_mid_strobes", 32'({wen1, ren1, ren2}), 32'd0);
    chk("rst_mid_addrs", 32'({wad1, rad1, rad2, din}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("rst_mid_ready", 32'({wr_ready, rd1_ready, rd2_ready}), 32'h7);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("rst_mid_quiet%0d", c), 32'({wen1, ren1, ren2}), 32'd0);
    end

    // ---------------- back-to-back streaming on rd1
    for (int i = 0; i < 8; i++) begin
      rd1_valid = 1'b1;
      rd1_addr = 5'(i + 16);
      chk($sformatf("stream_ready%0d", i), 32'(rd1_ready), 32'd1);
      tick();
      if (i > 0) chk($sformatf("stream_ren%0d", i), 32'({ren1, rad1}), 32'({1'b1, 5'(i + 15)}));
    end
    idle_inputs();
    tick();
    chk("stream_last", 32'({ren1, rad1}), 32'({1'b1, 5'd23}));
    tick();
    chk("stream_done", 32'(ren1), 32'd0);

    // ---------------- randomized run against the slot model
    do_reset();
    for (int k = 0; k < 3; k++) begin
      mv[k] = 1'b0; ma[k] = '0; mw[k] = 0;
    end
    mdat = '0; e_stb = '0; e_wad = '0; e_rad1 = '0; e_rad2 = '0; e_din = '0; e_stall = 0;

    for (int cyc = 0; cyc < 1500; cyc++) begin
      bit        iv[3];
      bit [4:0]  ia[3];
      bit [15:0] idat;
      bit        iss[3];
      bit        rdy[3];
      bit        any_stall;
      bit        coll;
      for (int k = 0; k < 3; k++) begin
        iv[k] = ($urandom_range(0, 99) < 60);
        ia[k] = 5'($urandom_range(0, 3));
      end
      idat = 16'($urandom);
      rd1_valid = iv[0]; rd1_addr = ia[0];
      rd2_valid = iv[1]; rd2_addr = ia[1];
      wr_valid = iv[2]; wr_addr = ia[2]; wr_data = idat;

      // An occupied slot issues unless an occupied same-address slot outranks it.
      any_stall = 1'b0;
      for (int i = 0; i < 3; i++) begin
        iss[i] = mv[i];
        for (int j = 0; j < 3; j++)
          if (j != i && mv[j] && mv[i] && ma[j] == ma[i] &&
              (mw[j] * 4 + pri(j)) > (mw[i] * 4 + pri(i)))
            iss[i] = 1'b0;
        rdy[i] = !mv[i] || iss[i];
        if (mv[i] && !iss[i]) any_stall = 1'b1;
      end
      chk("rand_ready", 32'({wr_ready, rd1_ready, rd2_ready}), 32'({rdy[2], rdy[0], rdy[1]}));

      e_stb = {iss[2], iss[0], iss[1]};
      if (iss[2]) begin e_wad = ma[2]; e_din = mdat; end
      if (iss[0]) e_rad1 = ma[0];
      if (iss[1]) e_rad2 = ma[1];
      if (any_stall && e_stall < 65535) e_stall++;
      for (int k = 0; k < 3; k++) begin
        if (iv[k] && rdy[k]) begin
          mv[k] = 1'b1; ma[k] = ia[k]; mw[k] = 0;
          if (k == 2) mdat = idat;
        end else if (iss[k]) begin
          mv[k] = 1'b0; mw[k] = 0;
        end else if (mv[k] && mw[k] < 3) begin
          mw[k]++;
        end
      end

      tick();
      chk("rand_strobes", 32'({wen1, ren1, ren2}), 32'(e_stb));
      chk("rand_addrs", 32'({wad1, rad1, rad2}), 32'({e_wad, e_rad1, e_rad2}));
      chk("rand_din", 32'(din), 32'(e_din));
      coll = (wen1 && ren1 && wad1 == rad1) || (wen1 && ren2 && wad1 == rad2) ||
             (ren1 && ren2 && rad1 == rad2);
      chk("rand_collision", 32'(coll), 32'd0);
`ifdef REGFILE_ISSUE_ARB_STATS_EN
      chk("rand_stall", 32'(stall_cnt), 32'(e_stall));
`endif
    end
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
